// File: rtl/vga_synch_gen.sv
// VGA pixel-rate timing: prescaled pixel enable, H/V synch-time counters, sync and display decode.
// Optional FRAME_START output is enabled by defining FRAME_START_EN.
module vga_synch_gen #(
   parameter int unsigned ClkDiv      = 2,
   parameter int unsigned HPulse      = 96,
   parameter int unsigned HBackPorch  = 48,
   parameter int unsigned HDisplay    = 640,
   parameter int unsigned HFrontPorch = 16,
   parameter int unsigned VPulse      = 2,
   parameter int unsigned VBackPorch  = 33,
   parameter int unsigned VDisplay    = 480,
   parameter int unsigned VFrontPorch = 10
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       PIX_EN,
   output logic [9:0] H_SYNCH_TIME,
   output logic [9:0] V_SYNCH_TIME,
   output logic       HSYNCH,
   output logic       VSYNCH,
   output logic       DISPLAY_ON
`ifdef FRAME_START_EN
   ,
   output logic       FRAME_START
`endif
);

   localparam int unsigned HTotal = HPulse + HBackPorch + HDisplay + HFrontPorch;
   localparam int unsigned VTotal = VPulse + VBackPorch + VDisplay + VFrontPorch;

   localparam logic [3:0]  DivLast   = 4'(ClkDiv - 1);
   localparam logic [9:0]  HLast     = 10'(HTotal - 1);
   localparam logic [9:0]  VLast     = 10'(VTotal - 1);
   // Region bounds are 11 bits so a display window ending at 1024 still fits.
   localparam logic [10:0] HPulseEnd = 11'(HPulse);
   localparam logic [10:0] HDispBeg  = 11'(HPulse + HBackPorch);
   localparam logic [10:0] HDispEnd  = 11'(HPulse + HBackPorch + HDisplay);
   localparam logic [10:0] VPulseEnd = 11'(VPulse);
   localparam logic [10:0] VDispBeg  = 11'(VPulse + VBackPorch);
   localparam logic [10:0] VDispEnd  = 11'(VPulse + VBackPorch + VDisplay);

   logic [3:0]  div_cnt_q, div_cnt_d;
   logic        pix_en_q;
   logic [9:0]  h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic        hsynch_q, vsynch_q, display_on_q;
   logic [10:0] h_ext, v_ext;

   always_comb begin
      div_cnt_d = (div_cnt_q == DivLast) ? 4'd0 : div_cnt_q + 4'd1;
      h_d       = h_q;
      v_d       = v_q;
      if (pix_en_q) begin
         if (h_q == HLast) begin
            h_d = 10'd0;
            v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
      h_ext = {1'b0, h_d};
      v_ext = {1'b0, v_d};
   end

   // Flags decode the next counter values so they line up with H/V on the outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt_q    <= 4'd0;
         pix_en_q     <= (ClkDiv == 1);
         h_q          <= 10'd0;
         v_q          <= 10'd0;
         hsynch_q     <= 1'b0;
         vsynch_q     <= 1'b0;
         display_on_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         pix_en_q     <= (div_cnt_d == DivLast);
         h_q          <= h_d;
         v_q          <= v_d;
         hsynch_q     <= (h_ext >= HPulseEnd);
         vsynch_q     <= (v_ext >= VPulseEnd);
         display_on_q <= (h_ext >= HDispBeg) && (h_ext < HDispEnd) &&
                         (v_ext >= VDispBeg) && (v_ext < VDispEnd);
      end
   end

   assign PIX_EN       = pix_en_q;
   assign H_SYNCH_TIME = h_q;
   assign V_SYNCH_TIME = v_q;
   assign HSYNCH       = hsynch_q;
   assign VSYNCH       = vsynch_q;
   assign DISPLAY_ON   = display_on_q;

`ifdef FRAME_START_EN
   logic frame_start_q;

   // Only a genuine wrap from the last position pulses; the reset-induced (0,0) does not.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= pix_en_q && (h_q == HLast) && (v_q == VLast);
      end
   end

   assign FRAME_START = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_synch_gen.sv
// Directed bench for vga_synch_gen: default 640x480 timing plus a tiny ClkDiv=1 instance.
module tb_vga_synch_gen;

   logic       clk = 1'b0;
   logic       rst_d, rst_s;
   logic       d_pix, d_hs, d_vs, d_disp;
   logic [9:0] d_h, d_v;
   logic       s_pix, s_hs, s_vs, s_disp;
   logic [9:0] s_h, s_v;
`ifdef FRAME_START_EN
   logic       d_fs, s_fs;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int k;
   int errs, first_bad, hs_low_l1, disp_l35, disp_early, fs_cnt;
   int h_pre, v_pre, h_post, v_post;

   always #5 clk = ~clk;

   vga_synch_gen dut_d (
      .CLK          (clk),
      .RESET        (rst_d),
      .PIX_EN       (d_pix),
      .H_SYNCH_TIME (d_h),
      .V_SYNCH_TIME (d_v),
      .HSYNCH       (d_hs),
      .VSYNCH       (d_vs),
      .DISPLAY_ON   (d_disp)
`ifdef FRAME_START_EN
      ,
      .FRAME_START  (d_fs)
`endif
   );

   vga_synch_gen #(
      .ClkDiv      (1),
      .HPulse      (2),
      .HBackPorch  (2),
      .HDisplay    (4),
      .HFrontPorch (2),
      .VPulse      (1),
      .VBackPorch  (1),
      .VDisplay    (3),
      .VFrontPorch (1)
   ) dut_s (
      .CLK          (clk),
      .RESET        (rst_s),
      .PIX_EN       (s_pix),
      .H_SYNCH_TIME (s_h),
      .V_SYNCH_TIME (s_v),
      .HSYNCH       (s_hs),
      .VSYNCH       (s_vs),
      .DISPLAY_ON   (s_disp)
`ifdef FRAME_START_EN
      ,
      .FRAME_START  (s_fs)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advances the default instance to edge 'upto' after release, tallying deviations from
   // the closed-form timing: H = (k/2) mod 800, V = (k/1600) mod 525, PIX_EN = k odd.
   task automatic run_default(input int upto);
      int t, eh, ev;
      logic epix, ehs, evs, edisp, bad;
      errs = 0; first_bad = -1; hs_low_l1 = 0; disp_l35 = 0; disp_early = 0; fs_cnt = 0;
      while (k < upto) begin
         tick();
         k++;
         t     = k / 2;
         eh    = t % 800;
         ev    = (t / 800) % 525;
         epix  = (k % 2 == 1);
         ehs   = (eh >= 96);
         evs   = (ev >= 2);
         edisp = (eh >= 144) && (eh < 784) && (ev >= 35) && (ev < 515);
         bad   = (d_pix !== epix) || (d_h !== 10'(eh)) || (d_v !== 10'(ev)) ||
                 (d_hs !== ehs) || (d_vs !== evs) || (d_disp !== edisp);
         if (bad) begin
            errs++;
            if (first_bad < 0) first_bad = k;
         end
         if (k >= 1600 && k < 3200 && d_hs === 1'b0) hs_low_l1++;
         if (k >= 56000 && k < 57600 && d_disp === 1'b1) disp_l35++;
         if (k < 56000 && d_disp === 1'b1) disp_early++;
         if (k == 1599) begin h_pre = int'(d_h); v_pre = int'(d_v); end
         if (k == 1600) begin h_post = int'(d_h); v_post = int'(d_v); end
`ifdef FRAME_START_EN
         if (d_fs === 1'b1) fs_cnt++;
`endif
      end
   endtask

   task automatic test_reset();
      rst_d = 1'b1;
      rst_s = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({d_h, d_v, d_hs, d_vs, d_disp, d_pix} !== 24'd0) begin
            n_bad++;
            $display("FAIL reset_default: got h=%0d v=%0d hs=%b vs=%b disp=%b pix=%b, want all 0",
                     d_h, d_v, d_hs, d_vs, d_disp, d_pix);
         end
         n_cmp++;
         if (s_pix !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_small_pix: got %b want 1", s_pix);
         end
`ifdef FRAME_START_EN
         n_cmp++;
         if (d_fs !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_frame_start: got %b want 0", d_fs);
         end
`endif
      end
      rst_d = 1'b0;
      rst_s = 1'b0;
      k = 0;
   endtask

   task automatic test_first_pixel();
      tick();
      k++;
      n_cmp++;
      if (d_pix !== 1'b1 || d_h !== 10'd0) begin
         n_bad++;
         $display("FAIL first_pix: got pix=%b h=%0d want pix=1 h=0", d_pix, d_h);
      end
      tick();
      k++;
      n_cmp++;
      if (d_pix !== 1'b0 || d_h !== 10'd1) begin
         n_bad++;
         $display("FAIL first_advance: got pix=%b h=%0d want pix=0 h=1", d_pix, d_h);
      end
   endtask

   task automatic test_horizontal();
      run_default(57600);
      n_cmp++;
      if (errs !== 0) begin
         n_bad++;
         $display("FAIL horiz_scan: %0d bad cycles (first k=%0d), want 0", errs, first_bad);
      end
      n_cmp++;
      if (hs_low_l1 !== 192) begin
         n_bad++;
         $display("FAIL hsynch_width: got %0d low cycles want 192 (96 ticks)", hs_low_l1);
      end
      n_cmp++;
      if (disp_l35 !== 1280) begin
         n_bad++;
         $display("FAIL display_line35: got %0d cycles want 1280", disp_l35);
      end
      n_cmp++;
      if (disp_early !== 0) begin
         n_bad++;
         $display("FAIL display_vblank: got %0d cycles want 0", disp_early);
      end
      n_cmp++;
      if (h_pre !== 799 || v_pre !== 0 || h_post !== 0 || v_post !== 1) begin
         n_bad++;
         $display("FAIL h_wrap: got (%0d,%0d)->(%0d,%0d) want (799,0)->(0,1)",
                  h_pre, v_pre, h_post, v_post);
      end
`ifdef FRAME_START_EN
      n_cmp++;
      if (fs_cnt !== 0) begin
         n_bad++;
         $display("FAIL frame_start_after_reset: got %0d pulses want 0", fs_cnt);
      end
`endif
   endtask

   task automatic test_mid_reset();
      run_default(58400);
      n_cmp++;
      if (errs !== 0 || d_h !== 10'd400 || d_v !== 10'd36) begin
         n_bad++;
         $display("FAIL pre_reset_pos: errs=%0d h=%0d v=%0d want 0,400,36", errs, d_h, d_v);
      end
      rst_d = 1'b1;
      tick();
      n_cmp++;
      if ({d_h, d_v, d_hs, d_vs, d_disp, d_pix} !== 24'd0) begin
         n_bad++;
         $display("FAIL mid_reset_values: got h=%0d v=%0d hs=%b vs=%b disp=%b pix=%b, want all 0",
                  d_h, d_v, d_hs, d_vs, d_disp, d_pix);
      end
      rst_d = 1'b0;
      k = 0;
      run_default(3300);
      n_cmp++;
      if (errs !== 0) begin
         n_bad++;
         $display("FAIL restart_scan: %0d bad cycles (first k=%0d), want 0", errs, first_bad);
      end
      n_cmp++;
      if (h_pre !== 799 || v_pre !== 0 || h_post !== 0 || v_post !== 1 || hs_low_l1 !== 192) begin
         n_bad++;
         $display("FAIL restart_line: got (%0d,%0d)->(%0d,%0d) hs_low=%0d want (799,0)->(0,1) 192",
                  h_pre, v_pre, h_post, v_post, hs_low_l1);
      end
   endtask

   // Tiny instance: HTotal=10, VTotal=6, one frame every 60 CLK cycles.
   task automatic test_small_frame();
      int eh, ev, s_err, s_first, pix_cnt, vs_low, disp_cnt, hs_low, s_fs_cnt;
      int h59, v59, h60, v60;
      logic ehs, evs, edisp, bad, hs60, vs60;
      rst_s = 1'b1;
      tick();
      n_cmp++;
      if ({s_h, s_v, s_hs, s_vs, s_disp} !== 23'd0 || s_pix !== 1'b1) begin
         n_bad++;
         $display("FAIL small_reset: got h=%0d v=%0d hs=%b vs=%b disp=%b pix=%b want 0s, pix=1",
                  s_h, s_v, s_hs, s_vs, s_disp, s_pix);
      end
      rst_s = 1'b0;
      s_err = 0; s_first = -1; pix_cnt = 0; vs_low = 0; disp_cnt = 0; hs_low = 0; s_fs_cnt = 0;
      h59 = 0; v59 = 0; h60 = 0; v60 = 0; hs60 = 1'b1; vs60 = 1'b1;
      for (int ks = 1; ks <= 180; ks++) begin
         tick();
         eh    = ks % 10;
         ev    = (ks / 10) % 6;
         ehs   = (eh >= 2);
         evs   = (ev >= 1);
         edisp = (eh >= 4) && (eh <= 7) && (ev >= 2) && (ev <= 4);
         bad   = (s_h !== 10'(eh)) || (s_v !== 10'(ev)) || (s_hs !== ehs) ||
                 (s_vs !== evs) || (s_disp !== edisp);
`ifdef FRAME_START_EN
         if (s_fs !== (ks % 60 == 0)) bad = 1'b1;
         if (s_fs === 1'b1) s_fs_cnt++;
`endif
         if (bad) begin
            s_err++;
            if (s_first < 0) s_first = ks;
         end
         if (s_pix === 1'b1) pix_cnt++;
         if (ks > 60 && ks <= 120) begin
            if (s_vs === 1'b0) vs_low++;
            if (s_hs === 1'b0) hs_low++;
            if (s_disp === 1'b1) disp_cnt++;
         end
         if (ks == 59) begin h59 = int'(s_h); v59 = int'(s_v); end
         if (ks == 60) begin h60 = int'(s_h); v60 = int'(s_v); hs60 = s_hs; vs60 = s_vs; end
      end
      n_cmp++;
      if (s_err !== 0) begin
         n_bad++;
         $display("FAIL small_scan: %0d bad cycles (first ks=%0d), want 0", s_err, s_first);
      end
      n_cmp++;
      if (pix_cnt !== 180) begin
         n_bad++;
         $display("FAIL small_pix_const: got %0d high cycles want 180", pix_cnt);
      end
      n_cmp++;
      if (h59 !== 9 || v59 !== 5 || h60 !== 0 || v60 !== 0 || hs60 !== 1'b0 || vs60 !== 1'b0) begin
         n_bad++;
         $display("FAIL frame_wrap: got (%0d,%0d)->(%0d,%0d) hs=%b vs=%b want (9,5)->(0,0) 0 0",
                  h59, v59, h60, v60, hs60, vs60);
      end
      n_cmp++;
      if (vs_low !== 10 || hs_low !== 12) begin
         n_bad++;
         $display("FAIL small_sync_widths: got vs_low=%0d hs_low=%0d want 10 12", vs_low, hs_low);
      end
      n_cmp++;
      if (disp_cnt !== 12) begin
         n_bad++;
         $display("FAIL small_display: got %0d cycles want 12", disp_cnt);
      end
`ifdef FRAME_START_EN
      n_cmp++;
      if (s_fs_cnt !== 3) begin
         n_bad++;
         $display("FAIL small_frame_start: got %0d pulses want 3", s_fs_cnt);
      end
`endif
   endtask

   initial begin
      rst_d = 1'b1;
      rst_s = 1'b1;
      test_reset();
      test_first_pixel();
      test_horizontal();
      test_mid_reset();
      test_small_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
